pt_fill_ctrl: RTL
=================

# pt_fill_ctrl

Sequencer that owns the write port of the 64-entry page table in the paging unit. It accepts single-entry writes and bulk "map range" fills from the CPU control path and arbitrates between them. It serialises each accepted request into clean, glitch-free WE strobes with WPTI/WPTE set up one full cycle before WE rises, because the page table captures on the WE rising edge. Sits between the CPU's MMU control registers and the paging unit's WE/WPTI/WPTE inputs.

## Interface
- No parameters; table geometry fixed at 64 entries × 16 bit, 10-bit frame field, 6-bit flag field.
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  reset Rst, asynchronous, active-high
- SglValid  in  1  single-write request
- SglIndex  in  6  target entry for single write
- SglPTE  in  16  entry value for single write
- FillValid  in  1  range-fill request
- FillStart  in  6  first entry index
- FillCount  in  7  number of entries, 0..64; values >64 are treated as 64
- FillBase  in  10  frame number written to first entry
- FillFlags  in  6  upper PTE bits, identical for all entries of the fill
- Abort  in  1  stop an active fill after the current entry
- Ready  out  1  high only in IDLE; a request is accepted on a rising edge where Ready & Valid
- Busy  out  1  high in SETUP, STROBE, DONE
- Done  out  1  one-cycle pulse when a request (single, fill, or aborted fill) completes
- WE  out  1  page-table write strobe (drives the paging unit's WE)
- WPTI  out  6  page-table write index
- WPTE  out  16  page-table write data

## Operation
- States: IDLE, SETUP, STROBE, DONE. All outputs are registered; there are no combinational paths from inputs to WE, WPTI, or WPTE.
- Arbitration in IDLE: SglValid wins over FillValid. A loser stays un-accepted; requesters hold Valid and fields until accepted.
- Single accept: latch SglIndex/SglPTE and set remaining=1. Go to SETUP.
- Fill accept: latch all Fill* fields, set k=0, and set remaining=min(FillCount,64).
  - FillCount=0: go directly to DONE with no WE pulse.
- SETUP: WPTI/WPTE are driven. For a fill, WPTI=(FillStart+k) mod 64 and WPTE={FillFlags,(FillBase+k) mod 1024}. WE=0. Next state is STROBE.
- STROBE: WE=1, with WPTI/WPTE unchanged. Then decrement remaining and increment k.
  - If remaining becomes 0, or Abort was sampled high during SETUP or STROBE of this entry: go to DONE.
  - Otherwise go to SETUP.
- DONE: Done=1 and WE=0. WPTI/WPTE hold their last values. Next state is IDLE.
- Index and frame wrap silently. A 64-entry fill rewrites every entry exactly once, regardless of start.
- Abort in IDLE or DONE is ignored. Abort never truncates an in-progress WE pulse.
- A single write always completes. Abort has no effect on it.
- Reset, async: state=IDLE, WE=0, WPTI=0, WPTE=0, Done=0, Busy=0, Ready=1, counters=0.
  - Reset mid-STROBE drops WE immediately. The paging unit is reset by the same Rst, so no partial entry matters.

## Timing
- Accept at edge N. SETUP occupies cycle N+1, STROBE cycle N+2 (WE high one cycle).
- Entry j (0-based): WE high in cycle N+2+2j. WE low in between, so there is exactly one rising edge per entry.
- WPTI/WPTE are stable from the start of SETUP through the end of STROBE. This gives one full cycle of setup before WE rises, and hold through WE high.
- Fill of n≥1 entries: Done in cycle N+2n+1, Ready again in cycle N+2n+2. Single write: Done in N+3.
- FillCount=0: Done in N+1, Ready in N+2.
- Throughput: one entry per 2 cycles, plus 2 cycles overhead per request.

## Test plan
- Reset, then single write SglIndex=5, SglPTE=0x1234 → WE high only in cycle N+2 with WPTI=5/WPTE=0x1234 stable from N+1; Done in N+3; Ready low N+1..N+3.
- Fill Start=60, Count=8, Base=0x3FE, Flags=0b000100 → 8 WE pulses at indices 60,61,62,63,0,1,2,3. WPTE runs 0x13FE, 0x13FF, 0x1000, 0x1001, ... (frame wraps). Done at N+17.
- SglValid and FillValid both high in IDLE → single serviced first. Fill accepted on the edge after Done (first edge in IDLE), then executes fully.
- Fill Count=64, Abort pulsed during the SETUP of entry 3 → entries 0..3 written (4 WE pulses); Done at N+9; entry 4 is never strobed.
- FillCount=0 → no WE pulse; Done at N+1. FillCount=100 → exactly 64 WE pulses.
- Assert Rst while WE=1 mid-fill → WE=0, Busy=0, Ready=1 immediately (asynchronously). After release, a new single write completes normally.

Source files
------------

// File: rtl/pt_fill_ctrl_if.sv
// Request/response bundle between the CPU's MMU control path and pt_fill_ctrl.
// The master side issues single writes and range fills and observes the
// page-table write port; the slave side is the sequencer itself.
interface pt_fill_ctrl_if;
    // single-entry write request
    logic        SglValid;
    logic [5:0]  SglIndex;
    logic [15:0] SglPTE;

    // range-fill request
    logic        FillValid;
    logic [5:0]  FillStart;
    logic [6:0]  FillCount;
    logic [9:0]  FillBase;
    logic [5:0]  FillFlags;
    logic        Abort;

    // status
    logic        Ready;
    logic        Busy;
    logic        Done;

    // page-table write port
    logic        WE;
    logic [5:0]  WPTI;
    logic [15:0] WPTE;

    modport master (
        output SglValid, SglIndex, SglPTE,
        output FillValid, FillStart, FillCount, FillBase, FillFlags, Abort,
        input  Ready, Busy, Done,
        input  WE, WPTI, WPTE
    );

    modport slave (
        input  SglValid, SglIndex, SglPTE,
        input  FillValid, FillStart, FillCount, FillBase, FillFlags, Abort,
        output Ready, Busy, Done,
        output WE, WPTI, WPTE
    );
endinterface

// File: rtl/pt_fill_ctrl.sv
// Page-table write sequencer. Accepts single-entry writes and range fills,
// arbitrates between them (single wins) and turns each entry into a clean
// WE pulse with WPTI/WPTE set up one full cycle before WE rises and held
// through the pulse. Every output comes straight from a flop.
module pt_fill_ctrl (
    input  logic          Clk,
    input  logic          Rst,
    pt_fill_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;

    // request bookkeeping
    logic [6:0]  remaining;      // entries still to strobe, 0..64
    logic [5:0]  k;              // offset of the current entry within a fill
    logic        is_fill;        // current request is a fill (abortable)
    logic        abort_seen;     // Abort caught during SETUP of this entry

    // latched fill geometry
    logic [5:0]  fill_start;
    logic [9:0]  fill_base;
    logic [5:0]  fill_flags;

    // registered outputs
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        we_q;
    logic [5:0]  wpti_q;
    logic [15:0] wpte_q;

    // helper terms used by the sequencer
    logic [6:0]  fill_len;       // requested count clamped to the table size
    logic [6:0]  remaining_next;
    logic [5:0]  k_next;
    logic        last_entry;     // the entry being strobed ends the request

    assign fill_len       = (bus.FillCount > 7'd64) ? 7'd64 : bus.FillCount;
    assign remaining_next = remaining - 7'd1;
    assign k_next         = k + 6'd1;
    // Abort only stops fills; a single write has remaining=1 and ends anyway.
    assign last_entry     = (remaining_next == 7'd0) ||
                            (is_fill && (abort_seen || bus.Abort));

    // Sequencer: state, counters and all outputs advance together.
    // NOTE: Rst sits in the sensitivity list so WE drops the instant reset is
    // asserted, even in the middle of a strobe.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            remaining  <= 7'd0;
            k          <= 6'd0;
            is_fill    <= 1'b0;
            abort_seen <= 1'b0;
            fill_start <= 6'd0;
            fill_base  <= 10'd0;
            fill_flags <= 6'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            wpti_q     <= 6'd0;
            wpte_q     <= 16'd0;
        end else begin
            // NOTE: every state/output update here is non-blocking so each
            // register sees the values from before this edge, never a mix.
            case (state)
                IDLE: begin
                    if (bus.SglValid) begin
                        // single write: one entry, address/data on the port now
                        wpti_q     <= bus.SglIndex;
                        wpte_q     <= bus.SglPTE;
                        remaining  <= 7'd1;
                        k          <= 6'd0;
                        is_fill    <= 1'b0;
                        abort_seen <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= SETUP;
                    end else if (bus.FillValid) begin
                        fill_start <= bus.FillStart;
                        fill_base  <= bus.FillBase;
                        fill_flags <= bus.FillFlags;
                        remaining  <= fill_len;
                        k          <= 6'd0;
                        is_fill    <= 1'b1;
                        abort_seen <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        if (fill_len == 7'd0) begin
                            // empty fill: complete without touching the port
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            wpti_q <= bus.FillStart;
                            wpte_q <= {bus.FillFlags, bus.FillBase};
                            state  <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    // address/data have been stable a full cycle; raise WE
                    we_q  <= 1'b1;
                    state <= STROBE;
                    if (is_fill && bus.Abort) begin
                        abort_seen <= 1'b1;
                    end
                end

                STROBE: begin
                    we_q      <= 1'b0;
                    remaining <= remaining_next;
                    k         <= k_next;
                    if (last_entry) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        // present the next entry; index and frame wrap silently
                        abort_seen <= 1'b0;
                        wpti_q     <= fill_start + k_next;
                        wpte_q     <= {fill_flags, fill_base + {4'd0, k_next}};
                        state      <= SETUP;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Ready = ready_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.WE    = we_q;
    assign bus.WPTI  = wpti_q;
    assign bus.WPTE  = wpte_q;

endmodule
